// File: rtl/maze_datapath.sv
// maze_datapath: datapath for the maze game controller.
// Holds the player position, key capture, obstacle-map probing, the
// move/freeze timer, the elapsed-seconds counter and the VGA pixel outputs.
// All enable/select strobes come from the controller FSM; this block only
// reports status (win, timer_done, unfrozen, move, obs_*) back to it.
module maze_datapath #(
    parameter int MAX_X        = 159,
    parameter int MAX_Y        = 119,
    parameter int START_X      = 0,
    parameter int START_Y      = 0,
    parameter int END_X        = 159,
    parameter int END_Y        = 119,
    parameter int TICKS        = 5_000_000,
    parameter int FREEZE_TICKS = 25_000_000,
    parameter int SEC_TICKS    = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_xpos,
    input  logic        en_ypos,
    input  logic [1:0]  s_xpos,
    input  logic [1:0]  s_ypos,
    input  logic        en_key,
    input  logic        s_key,
    input  logic        en_obs,
    input  logic [2:0]  s_obs,
    input  logic [1:0]  s_color,
    input  logic        plot,
    input  logic        en_timer,
    input  logic        s_timer,
    input  logic        en_clockt,
    input  logic        s_clockt,
    input  logic [3:0]  key_in,
    output logic [14:0] map_addr,
    input  logic [1:0]  map_data,
    output logic [2:0]  move,
    output logic        obs_wall,
    output logic        obs_lava,
    output logic        obs_ice,
    output logic        timer_done,
    output logic        unfrozen,
    output logic        win,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [7:0]  elapsed_s
);

    // Counter widths sized from the parameters so small values shrink them.
    localparam int TW = $clog2(FREEZE_TICKS + 1);
    localparam int PW = $clog2(SEC_TICKS + 1);

    localparam logic [TW-1:0] TIMER_MAX   = TW'(FREEZE_TICKS - 1);
    localparam logic [TW-1:0] TIMER_DONE  = TW'(TICKS - 1);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(SEC_TICKS - 1);
    localparam logic [14:0]   ROW_W       = 15'(MAX_X + 1);
    localparam logic [14:0]   START_ADDR  = 15'(START_Y * (MAX_X + 1) + START_X);
    localparam logic [7:0]    X_LAST      = 8'(MAX_X);
    localparam logic [6:0]    Y_LAST      = 7'(MAX_Y);

    // Direction codes shared by move and s_obs.
    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    logic [7:0]    xpos;
    logic [6:0]    ypos;
    logic [3:0]    pending;
    logic          oob;
    logic [TW-1:0] timer;
    logic [PW-1:0] prescaler;

    logic [7:0]    tgt_x;
    logic [6:0]    tgt_y;
    logic          tgt_oob;
    logic [14:0]   tgt_addr;

    // Priority among held keys: left, then right, then up, then down.
    function automatic logic [2:0] prio_dir(input logic [3:0] p);
        logic [2:0] d;
        d = DIR_NONE;
        if (p[0])      d = DIR_LEFT;
        else if (p[1]) d = DIR_RIGHT;
        else if (p[2]) d = DIR_UP;
        else if (p[3]) d = DIR_DOWN;
        return d;
    endfunction

    // x position: load start/end or step by one; bounds are the controller's job.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xpos <= 8'(START_X);
        end else if (en_xpos) begin
            case (s_xpos)
                2'd0:    xpos <= 8'(START_X);
                2'd1:    xpos <= xpos + 8'd1;
                2'd2:    xpos <= xpos - 8'd1;
                default: xpos <= 8'(END_X);
            endcase
        end
    end

    // y position: same scheme as x.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ypos <= 7'(START_Y);
        end else if (en_ypos) begin
            case (s_ypos)
                2'd0:    ypos <= 7'(START_Y);
                2'd1:    ypos <= ypos + 7'd1;
                2'd2:    ypos <= ypos - 7'd1;
                default: ypos <= 7'(END_Y);
            endcase
        end
    end

    // Key capture: keys accumulate in pending until the controller latches one.
    // A key arriving in the latch cycle is not lost; it seeds the next pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 4'd0;
            move    <= DIR_NONE;
        end else if (en_key) begin
            if (s_key) begin
                move    <= prio_dir(pending);
                pending <= key_in;
            end else begin
                move    <= DIR_NONE;
                pending <= 4'd0;
            end
        end else begin
            pending <= pending | key_in;
        end
    end

    // Probe target: neighbour cell in direction s_obs, or the current cell
    // (flagged off-grid) when the step would leave the playfield.
    always_comb begin
        tgt_x   = xpos;
        tgt_y   = ypos;
        tgt_oob = 1'b0;
        case (s_obs)
            DIR_LEFT: begin
                if (xpos == 8'd0) tgt_oob = 1'b1;
                else              tgt_x   = xpos - 8'd1;
            end
            DIR_RIGHT: begin
                if (xpos == X_LAST) tgt_oob = 1'b1;
                else                tgt_x   = xpos + 8'd1;
            end
            DIR_UP: begin
                if (ypos == 7'd0) tgt_oob = 1'b1;
                else              tgt_y   = ypos - 7'd1;
            end
            DIR_DOWN: begin
                if (ypos == Y_LAST) tgt_oob = 1'b1;
                else                tgt_y   = ypos + 7'd1;
            end
            default: ;
        endcase
        tgt_addr = 15'(tgt_y) * ROW_W + 15'(tgt_x);
    end

    // Probe address register feeding the synchronous obstacle ROM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            map_addr <= START_ADDR;
            oob      <= 1'b0;
        end else if (en_obs) begin
            map_addr <= tgt_addr;
            oob      <= tgt_oob;
        end
    end

    // ROM data arrives one cycle after map_addr; off-grid reads count as wall.
    assign obs_wall = oob | (map_data == 2'b01);
    assign obs_lava = !oob & (map_data == 2'b10);
    assign obs_ice  = !oob & (map_data == 2'b11);

    // Move/freeze timer, saturating so unfrozen stays asserted until cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (en_timer) begin
            if (!s_timer)               timer <= '0;
            else if (timer != TIMER_MAX) timer <= timer + 1'b1;
        end
    end

    assign timer_done = (timer >= TIMER_DONE);
    assign unfrozen   = (timer == TIMER_MAX);

    // Elapsed play time: prescaler divides clk into seconds, count saturates at 255.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler <= '0;
            elapsed_s <= 8'd0;
        end else if (en_clockt) begin
            if (!s_clockt) begin
                prescaler <= '0;
                elapsed_s <= 8'd0;
            end else if (prescaler == PRESC_MAX) begin
                prescaler <= '0;
                if (elapsed_s != 8'hFF) elapsed_s <= elapsed_s + 8'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    assign win = (xpos == 8'(END_X)) && (ypos == 7'(END_Y));

    // Pixel outputs follow the registered position directly.
    assign vga_x    = xpos;
    assign vga_y    = ypos;
    assign vga_plot = plot;

    // Colour palette lookup.
    always_comb begin
        vga_colour = 3'b000;
        case (s_color)
            2'd0:    vga_colour = 3'b000;
            2'd1:    vga_colour = 3'b010;
            2'd2:    vga_colour = 3'b011;
            default: vga_colour = 3'b100;
        endcase
    end

endmodule
